dbg_ctrl: RTL and testbench

DBG_CTRL -- requirements
Module: dbg_ctrl

---
 rtl/dbg_ctrl_if.sv | 22 ++
 rtl/dbg_ctrl.sv | 171 +++++++++++++++++
 tb/tb_dbg_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dbg_ctrl_if.sv
// rtl/dbg_ctrl_if.sv - command/response handshake bundle for the debug controller
interface dbg_ctrl_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic [4:0]  cmd_addr_i;
  logic [31:0] cmd_data_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, rsp_ready_i,
    output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
  );

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, rsp_ready_i,
    input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
  );
endinterface

// File: rtl/dbg_ctrl.sv
// rtl/dbg_ctrl.sv - debug command controller: halt/reset control and halted-only GPR access
module dbg_ctrl #(
  parameter int unsigned HALT_SETTLE  = 4,
  parameter int unsigned RESET_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  dbg_ctrl_if.slave   bus,
  output logic        jtag_halt_flag_o,
  output logic        jtag_reset_flag_o,
  output logic [4:0]  jtag_reg_addr_o,
  output logic [31:0] jtag_reg_data_o,
  output logic        jtag_reg_we_o,
  input  logic [31:0] jtag_reg_data_i
);

  typedef enum logic [2:0] {IDLE, HALT_WAIT, RST_PULSE, REG_RD, REG_WR, RESP} state_e;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b10;
  localparam logic [3:0] SETTLE_INIT = 4'(HALT_SETTLE);
  localparam logic [3:0] PULSE_INIT  = 4'(RESET_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  settle_q, settle_d;
  logic [3:0]  pulse_q, pulse_d;
  logic        halt_flag_q, halt_flag_d;
  logic        halted_q, halted_d;
  logic        ctrl_rst_q, ctrl_rst_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        accept;

  assign bus.cmd_ready_o = rst && (state_q == IDLE);
  assign accept          = bus.cmd_valid_i && bus.cmd_ready_o;

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    pulse_d     = pulse_q;
    halt_flag_d = halt_flag_q;
    halted_d    = halted_q;
    ctrl_rst_d  = ctrl_rst_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    // Status words latched on entry to RESP always carry reset_busy=0: the pulse is over by then.
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.cmd_op_i == OP_NOP) begin
            state_d    = RESP;
            rsp_data_d = {31'b0, halted_q};
            rsp_err_d  = 1'b0;
          end else if (bus.cmd_op_i == OP_RD || bus.cmd_op_i == OP_WR) begin
            if (!halted_q) begin
              state_d    = RESP;
              rsp_data_d = '0;
              rsp_err_d  = 1'b1;
            end else begin
              addr_d = bus.cmd_addr_i;
              if (bus.cmd_op_i == OP_WR) begin
                wdata_d = bus.cmd_data_i;
                state_d = REG_WR;
              end else begin
                state_d = REG_RD;
              end
            end
          end else begin
            ctrl_rst_d = bus.cmd_data_i[1];
            if (bus.cmd_data_i[0]) begin
              halt_flag_d = 1'b1;
            end else begin
              halt_flag_d = 1'b0;
              halted_d    = 1'b0;
            end
            if (bus.cmd_data_i[0] && !halted_q) begin
              settle_d = SETTLE_INIT;
              state_d  = HALT_WAIT;
            end else if (bus.cmd_data_i[1]) begin
              pulse_d = PULSE_INIT;
              state_d = RST_PULSE;
            end else begin
              state_d    = RESP;
              rsp_data_d = {31'b0, halted_d};
              rsp_err_d  = 1'b0;
            end
          end
        end
      end
      HALT_WAIT: begin
        settle_d = settle_q - 4'd1;
        if (settle_q <= 4'd1) begin
          settle_d = '0;
          halted_d = 1'b1;
          if (ctrl_rst_q) begin
            pulse_d = PULSE_INIT;
            state_d = RST_PULSE;
          end else begin
            state_d    = RESP;
            rsp_data_d = 32'h1;
            rsp_err_d  = 1'b0;
          end
        end
      end
      RST_PULSE: begin
        pulse_d = pulse_q - 4'd1;
        if (pulse_q <= 4'd1) begin
          pulse_d    = '0;
          state_d    = RESP;
          rsp_data_d = {31'b0, halted_q};
          rsp_err_d  = 1'b0;
        end
      end
      REG_RD: begin
        state_d    = RESP;
        rsp_data_d = jtag_reg_data_i;
        rsp_err_d  = 1'b0;
      end
      REG_WR: begin
        state_d    = RESP;
        rsp_data_d = wdata_q;
        rsp_err_d  = 1'b0;
      end
      RESP: begin
        if (bus.rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      settle_q    <= '0;
      pulse_q     <= '0;
      halt_flag_q <= 1'b0;
      halted_q    <= 1'b0;
      ctrl_rst_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      pulse_q     <= pulse_d;
      halt_flag_q <= halt_flag_d;
      halted_q    <= halted_d;
      ctrl_rst_q  <= ctrl_rst_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.rsp_valid_o   = (state_q == RESP);
  assign bus.rsp_data_o    = rsp_data_q;
  assign bus.rsp_err_o     = rsp_err_q;
  assign jtag_halt_flag_o  = halt_flag_q;
  assign jtag_reset_flag_o = (state_q == RST_PULSE);
  assign jtag_reg_we_o     = (state_q == REG_WR);
  assign jtag_reg_addr_o   = addr_q;
  assign jtag_reg_data_o   = wdata_q;

endmodule

// File: tb/tb_dbg_ctrl.sv
// tb/tb_dbg_ctrl.sv - scoreboard bench for dbg_ctrl with a small GPR file model
module tb_dbg_ctrl;
  logic        clk;
  logic        rst;
  logic        halt_flag, reset_flag, reg_we;
  logic [4:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic [31:0] regs [32];

  dbg_ctrl_if bus();

  dbg_ctrl #(.HALT_SETTLE(4), .RESET_CYCLES(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus),
    .jtag_halt_flag_o  (halt_flag),
    .jtag_reset_flag_o (reset_flag),
    .jtag_reg_addr_o   (reg_addr),
    .jtag_reg_data_o   (reg_wdata),
    .jtag_reg_we_o     (reg_we),
    .jtag_reg_data_i   (reg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h1000 + i;
    end else if (reg_we) begin
      regs[reg_addr] <= reg_wdata;
    end
  end
  assign reg_rdata = regs[reg_addr];

  logic [32:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt  = 0;

  localparam logic [1:0] NOP = 2'b00, RD = 2'b01, WR = 2'b10, CTL = 2'b11;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (reg_we === 1'b1) we_cnt++;
      if (rst && bus.rsp_valid_o && bus.rsp_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", {31'b0, bus.rsp_err_o, bus.rsp_data_o}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("rsp", {31'b0, bus.rsp_err_o, bus.rsp_data_o}, {31'b0, e});
        end
      end
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] data,
                      input logic e_err, input logic [31:0] e_data);
    int n = 0;
    while (!bus.cmd_ready_o && n < 200) begin
      @(posedge clk); #2; n++;
    end
    check("cmd_ready_timeout", {63'b0, bus.cmd_ready_o}, 64'd1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i    = op;
    bus.cmd_addr_i  = addr;
    bus.cmd_data_i  = data;
    exp_q.push_back({e_err, e_data});
    @(posedge clk); #2;
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !bus.cmd_ready_o) && n < 200) begin
      @(posedge clk); #2; n++;
    end
    check("idle_timeout", {63'b0, (exp_q.size() == 0 && bus.cmd_ready_o)}, 64'd1);
  endtask

  task automatic cycles_to_rsp(output int n);
    n = 0;
    while (!bus.rsp_valid_o && n < 60) begin
      @(posedge clk); #2; n++;
    end
  endtask

  initial begin
    int n, n_r, first_r, we_base;
    rst             = 1'b0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_op_i    = '0;
    bus.cmd_addr_i  = '0;
    bus.cmd_data_i  = '0;
    bus.rsp_ready_i = 1'b1;
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    #2;
    check("rst_cmd_ready", {63'b0, bus.cmd_ready_o}, 64'd0);
    check("rst_rsp", {29'b0, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_data_o}, 64'd0);
    check("rst_jtag", {26'b0, halt_flag, reset_flag, reg_we, reg_addr}, 64'd0);
    check("rst_wdata", {32'b0, reg_wdata}, 64'd0);
    rst = 1'b1;
    #1;
    check("ready_after_rst", {63'b0, bus.cmd_ready_o}, 64'd1);
    @(posedge clk); #2;

    // read while running: refused, no register access
    we_base = we_cnt;
    send(RD, 5'd5, 32'h0, 1'b1, 32'h0);
    wait_idle();
    check("rd_unhalted_no_we", 64'(we_cnt - we_base), 64'd0);
    send(WR, 5'd3, 32'h1234, 1'b1, 32'h0);
    wait_idle();
    check("wr_unhalted_no_we", 64'(we_cnt - we_base), 64'd0);
    send(NOP, 5'd0, 32'h0, 1'b0, 32'h0);
    wait_idle();

    // halt: flag next cycle, response after 4 settle cycles
    send(CTL, 5'd0, 32'h1, 1'b0, 32'h1);
    check("halt_flag_next", {63'b0, halt_flag}, 64'd1);
    cycles_to_rsp(n);
    check("halt_settle_cycles", 64'(n), 64'd4);
    wait_idle();

    // halted write of x7, then read back
    we_base = we_cnt;
    send(WR, 5'd7, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF);
    check("wr_strobe", {26'b0, reg_we, reg_addr, reg_wdata}, {26'b0, 1'b1, 5'd7, 32'hDEADBEEF});
    wait_idle();
    check("wr_single_we", 64'(we_cnt - we_base), 64'd1);
    check("wr_reg_model", {32'b0, regs[7]}, {32'b0, 32'hDEADBEEF});
    send(RD, 5'd7, 32'h0, 1'b0, 32'hDEADBEEF);
    check("rd_not_yet_valid", {62'b0, bus.rsp_valid_o, reg_we}, 64'd0);
    @(posedge clk); #2;
    check("rd_latency2", {63'b0, bus.rsp_valid_o}, 64'd1);
    wait_idle();
    send(RD, 5'd3, 32'h0, 1'b0, 32'h1003);
    wait_idle();
    send(WR, 5'd0, 32'h5, 1'b0, 32'h5);
    wait_idle();
    send(NOP, 5'd0, 32'h0, 1'b0, 32'h1);
    wait_idle();

    // un-halt, then halt+reset from running
    send(CTL, 5'd0, 32'h0, 1'b0, 32'h0);
    check("unhalt_flag", {63'b0, halt_flag}, 64'd0);
    wait_idle();
    send(CTL, 5'd0, 32'h3, 1'b0, 32'h1);
    n = 0; n_r = 0; first_r = -1;
    while (!bus.rsp_valid_o && n < 60) begin
      if (reset_flag) begin
        if (first_r < 0) first_r = n;
        n_r++;
      end
      @(posedge clk); #2; n++;
    end
    check("hr_first_reset", 64'(first_r), 64'd4);
    check("hr_reset_width", 64'(n_r), 64'd2);
    check("hr_total_cycles", 64'(n), 64'd6);
    wait_idle();

    // halt while already halted: no settle time
    send(CTL, 5'd0, 32'h1, 1'b0, 32'h1);
    check("rehalt_no_settle", {63'b0, bus.rsp_valid_o}, 64'd1);
    wait_idle();

    // response backpressure
    bus.rsp_ready_i = 1'b0;
    send(NOP, 5'd0, 32'h0, 1'b0, 32'h1);
    for (int i = 0; i < 5; i++) begin
      check("bp_stable", {29'b0, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_data_o, bus.cmd_ready_o},
            {29'b0, 1'b1, 1'b0, 32'h1, 1'b0});
      @(posedge clk); #2;
    end
    bus.rsp_ready_i = 1'b1;
    wait_idle();

    // reset during the PC-reset pulse
    send(CTL, 5'd0, 32'h3, 1'b0, 32'h1);
    check("mid_pulse", {62'b0, reset_flag, halt_flag}, 64'd3);
    rst = 1'b0;
    void'(exp_q.pop_back());
    @(posedge clk); #2;
    check("abort_outputs", {60'b0, reset_flag, halt_flag, bus.rsp_valid_o, reg_we}, 64'd0);
    rst = 1'b1;
    #1;
    check("abort_ready", {63'b0, bus.cmd_ready_o}, 64'd1);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      if (bus.rsp_valid_o) n++;
    end
    check("abort_no_rsp", 64'(n), 64'd0);
    send(NOP, 5'd0, 32'h0, 1'b0, 32'h0);
    wait_idle();
    send(WR, 5'd9, 32'hABCD, 1'b1, 32'h0);
    wait_idle();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
